// File: rtl/sonic_st_rx_lane_adapter_if.sv
// Avalon-ST RX stream from the hard IP plus the per-lane application stream.
// slave is the adapter's view; master is the surrounding environment's view.
interface sonic_st_rx_lane_adapter_if #(
  parameter int LANES   = 2,
  parameter int BAR_W   = 8,
  parameter int EMPTY_W = $clog2(LANES)
) ();
  logic [64*LANES-1:0] rx_st_data;
  logic [8*LANES-1:0]  rx_st_be;
  logic [BAR_W-1:0]    rx_st_bardec;
  logic                rx_st_sop;
  logic                rx_st_eop;
  logic [EMPTY_W-1:0]  rx_st_empty;
  logic                rx_st_err;
  logic                rx_st_valid;
  logic                rx_st_ready;
  logic [82*LANES-1:0] out_data;
  logic [LANES-1:0]    out_lane_vld;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  rx_st_data, rx_st_be, rx_st_bardec, rx_st_sop, rx_st_eop,
           rx_st_empty, rx_st_err, rx_st_valid, out_ready,
    output rx_st_ready, out_data, out_lane_vld, out_err, out_valid
  );

  modport master (
    output rx_st_data, rx_st_be, rx_st_bardec, rx_st_sop, rx_st_eop,
           rx_st_empty, rx_st_err, rx_st_valid, out_ready,
    input  rx_st_ready, out_data, out_lane_vld, out_err, out_valid
  );
endinterface

// File: rtl/sonic_st_rx_lane_adapter.sv
// Avalon-ST RX lane adapter: credit-reserved beat FIFO honouring READY_LATENCY,
// per-lane 82-bit words with last/valid masking, protocol checks and packet counting.
module sonic_st_rx_lane_adapter #(
  parameter int LANES         = 2,
  parameter int BAR_W         = 8,
  parameter int READY_LATENCY = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int EMPTY_W       = $clog2(LANES)
) (
  input  logic                        clk_in,
  input  logic                        rstn,
  sonic_st_rx_lane_adapter_if.slave   st,
  input  logic                        rx_stream_mask,
  input  logic                        stat_clear,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 pkt_count,
  output logic                        err_overflow,
  output logic                        err_proto
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int WW   = 82 * LANES;
  localparam int SR_W = (READY_LATENCY > 0) ? READY_LATENCY : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW:0]   DEPTH_C = (LW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_IN_PKT} pkt_state_t;

  logic [WW-1:0]    r_mem_data [FIFO_DEPTH];
  logic [LANES-1:0] r_mem_vld  [FIFO_DEPTH];
  logic             r_mem_err  [FIFO_DEPTH];
  logic             r_mem_eop  [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [SR_W-1:0]  r_rdy_sr;
  logic [31:0]      r_pkt_count;
  logic             r_err_overflow, r_err_proto;
  pkt_state_t       r_pkt_state, w_pkt_state_nxt;

  logic             w_proto_err, w_nonempty, w_full, w_pop, w_write, w_overflow;
  logic             w_ready_nxt;
  logic [LW-1:0]    w_level_nxt;
  logic [LW:0]      w_inflight;
  logic [7:0]       w_bar;
  logic [WW-1:0]    w_word;
  logic [LANES-1:0] w_lane_vld;

  generate
    if (BAR_W >= 8) begin : g_bar_trunc
      assign w_bar = st.rx_st_bardec[7:0];
    end else begin : g_bar_ext
      assign w_bar = {{(8 - BAR_W){1'b0}}, st.rx_st_bardec};
    end
  endgenerate

  assign w_nonempty  = (r_level != '0);
  assign w_full      = (r_level == DEPTH_L);
  assign w_pop       = w_nonempty && st.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
  assign w_write     = st.rx_st_valid && (!w_full || w_pop);
  assign w_overflow  = st.rx_st_valid && w_full && !w_pop;
  assign w_level_nxt = r_level + LW'(w_write) - LW'(w_pop);

  // Bit i of r_rdy_sr is the ready driven i cycles ago; bits below READY_LATENCY
  // still owe the FIFO a beat.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < READY_LATENCY; i++) begin
      w_inflight = w_inflight + (LW + 1)'(r_rdy_sr[i]);
    end
    w_ready_nxt = !rx_stream_mask && (({1'b0, w_level_nxt} + w_inflight) < DEPTH_C);
  end

  // Lane i is the last lane when empty == LANES-1-i; lanes above it are masked.
  always_comb begin
    w_word     = '0;
    w_lane_vld = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_vld[i] = !st.rx_st_eop || (EMPTY_W'(LANES - 1 - i) >= st.rx_st_empty);
      w_word[82*i +: 82] = {st.rx_st_be[8*i +: 8], st.rx_st_sop,
                            st.rx_st_eop && (EMPTY_W'(LANES - 1 - i) == st.rx_st_empty),
                            w_bar, st.rx_st_data[64*i +: 64]};
    end
  end

  always_comb begin
    w_pkt_state_nxt = r_pkt_state;
    w_proto_err     = 1'b0;
    if (st.rx_st_valid) begin
      case (r_pkt_state)
        S_IDLE: begin
          w_proto_err = !st.rx_st_sop;
          if (st.rx_st_sop && !st.rx_st_eop) w_pkt_state_nxt = S_IN_PKT;
        end
        S_IN_PKT: begin
          w_proto_err = st.rx_st_sop;
          if (st.rx_st_eop) w_pkt_state_nxt = S_IDLE;
        end
        default: w_pkt_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_write) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_vld[r_wr_ptr]  <= w_lane_vld;
      r_mem_err[r_wr_ptr]  <= st.rx_st_err;
      r_mem_eop[r_wr_ptr]  <= st.rx_st_eop;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_rdy_sr       <= '0;
      r_pkt_state    <= S_IDLE;
      r_pkt_count    <= '0;
      r_err_overflow <= 1'b0;
      r_err_proto    <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level     <= w_level_nxt;
      r_rdy_sr[0] <= w_ready_nxt;
      for (int unsigned i = 1; i < SR_W; i++) begin
        r_rdy_sr[i] <= r_rdy_sr[i-1];
      end
      r_pkt_state <= w_pkt_state_nxt;
      if (stat_clear) begin
        r_pkt_count    <= '0;
        r_err_overflow <= 1'b0;
        r_err_proto    <= 1'b0;
      end else begin
        if (w_pop && r_mem_eop[r_rd_ptr]) r_pkt_count <= r_pkt_count + 1'b1;
        if (w_overflow)  r_err_overflow <= 1'b1;
        if (w_proto_err) r_err_proto    <= 1'b1;
      end
    end
  end

  assign st.rx_st_ready  = r_rdy_sr[0];
  assign st.out_valid    = w_nonempty;
  assign st.out_data     = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
  assign st.out_lane_vld = w_nonempty ? r_mem_vld[r_rd_ptr]  : '0;
  assign st.out_err      = w_nonempty && r_mem_err[r_rd_ptr];
  assign fifo_level      = r_level;
  assign pkt_count       = r_pkt_count;
  assign err_overflow    = r_err_overflow;
  assign err_proto       = r_err_proto;
endmodule

// File: tb/tb_sonic_st_rx_lane_adapter.sv
// Directed bench for the RX lane adapter: a 2-lane instance exercises flow control,
// overflow, protocol and reset; a 4-lane instance checks tail-lane masking.
module tb_sonic_st_rx_lane_adapter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_stream_mask = 1'b0;
  logic        stat_clear = 1'b0;
  logic [3:0]  lvl2, lvl4;
  logic [31:0] pkt2, pkt4;
  logic        ovf2, ovf4, pro2, pro4;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [1:0]  h;
  logic        v;
  int          sent;

  always #5 clk = ~clk;

  sonic_st_rx_lane_adapter_if #(.LANES(2), .BAR_W(8)) if2 ();
  sonic_st_rx_lane_adapter_if #(.LANES(4), .BAR_W(8)) if4 ();

  sonic_st_rx_lane_adapter #(.LANES(2), .BAR_W(8), .READY_LATENCY(2), .FIFO_DEPTH(8)) u_dut2 (
    .clk_in(clk), .rstn(rstn), .st(if2), .rx_stream_mask(rx_stream_mask),
    .stat_clear(stat_clear), .fifo_level(lvl2), .pkt_count(pkt2),
    .err_overflow(ovf2), .err_proto(pro2));

  sonic_st_rx_lane_adapter #(.LANES(4), .BAR_W(8), .READY_LATENCY(2), .FIFO_DEPTH(8)) u_dut4 (
    .clk_in(clk), .rstn(rstn), .st(if4), .rx_stream_mask(rx_stream_mask),
    .stat_clear(stat_clear), .fifo_level(lvl4), .pkt_count(pkt4),
    .err_overflow(ovf4), .err_proto(pro4));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [81:0] lw(input logic [7:0] be, input logic sop, input logic last,
                                     input logic [7:0] bar, input logic [63:0] d);
    return {be, sop, last, bar, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic vld, input logic sop, input logic eop, input logic emp,
                        input logic err, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [15:0] be, input logic [7:0] bar);
    if2.rx_st_valid  = vld;
    if2.rx_st_sop    = sop;
    if2.rx_st_eop    = eop;
    if2.rx_st_empty  = emp;
    if2.rx_st_err    = err;
    if2.rx_st_data   = {d1, d0};
    if2.rx_st_be     = be;
    if2.rx_st_bardec = bar;
  endtask

  initial begin
    drive2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    if2.out_ready = 1'b1;
    if4.rx_st_valid = 1'b0; if4.rx_st_sop = 1'b0; if4.rx_st_eop = 1'b0;
    if4.rx_st_empty = '0; if4.rx_st_err = 1'b0; if4.rx_st_data = '0;
    if4.rx_st_be = '0; if4.rx_st_bardec = '0; if4.out_ready = 1'b1;

    // reset state
    tick(); tick();
    check("rst_ready", if2.rx_st_ready, 0);
    check("rst_valid", if2.out_valid, 0);
    check("rst_data", if2.out_data, 0);
    check("rst_vld", if2.out_lane_vld, 0);
    check("rst_level", lvl2, 0);
    check("rst_pkt", pkt2, 0);
    check("rst_errs", {ovf2, pro2, if2.out_err}, 0);
    rstn = 1'b1;
    tick();
    check("rel_ready2", if2.rx_st_ready, 1);
    check("rel_ready4", if4.rx_st_ready, 1);

    // 3-beat packet, eop with one empty lane
    drive2(1, 1, 0, 0, 0, 64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001, 16'hFFFF, 8'h04);
    tick();
    check("b0_l0", if2.out_data[81:0], lw(8'hFF, 1, 0, 8'h04, 64'hA000_0000_0000_0000));
    check("b0_l1", if2.out_data[163:82], lw(8'hFF, 1, 0, 8'h04, 64'hA000_0000_0000_0001));
    check("b0_vld", if2.out_lane_vld, 2'b11);
    drive2(1, 0, 0, 0, 1, 64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003, 16'h0FF0, 8'h04);
    tick();
    check("b1_l0", if2.out_data[81:0], lw(8'hF0, 0, 0, 8'h04, 64'hA000_0000_0000_0002));
    check("b1_err", if2.out_err, 1);
    drive2(1, 0, 1, 1, 0, 64'hA000_0000_0000_0004, 64'hA000_0000_0000_0005, 16'h00FF, 8'h04);
    tick();
    check("b2_l0", if2.out_data[81:0], lw(8'hFF, 0, 1, 8'h04, 64'hA000_0000_0000_0004));
    check("b2_l1", if2.out_data[163:82], lw(8'h00, 0, 0, 8'h04, 64'hA000_0000_0000_0005));
    check("b2_vld", if2.out_lane_vld, 2'b01);
    check("b2_err", if2.out_err, 0);
    drive2(0, 0, 0, 0, 0, '0, '0, '0, '0);
    tick();
    check("p1_pkt", pkt2, 1);
    check("p1_empty", if2.out_valid, 0);
    check("p1_proto", pro2, 0);

    // backpressure with a source that answers ready after two cycles
    if2.out_ready = 1'b0;
    h = '0;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      v = h[1];
      h = {h[0], if2.rx_st_ready};
      if (v) begin
        drive2(1, 1, 1, 0, 0, 64'h2000 + 64'(sent), '0, 16'hFFFF, 8'h01);
        sent++;
      end else begin
        if2.rx_st_valid = 1'b0;
      end
      tick();
    end
    if2.rx_st_valid = 1'b0;
    check("bp_sent", sent, 8);
    check("bp_level", lvl2, 8);
    check("bp_ready", if2.rx_st_ready, 0);
    check("bp_ovf", ovf2, 0);
    if2.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_drain", if2.out_data[63:0], 64'h2000 + 64'(k));
      tick();
    end
    check("bp_level0", lvl2, 0);
    check("bp_pkt", pkt2, 9);

    // forced beats past full, then clear and a full+pop+write cycle
    if2.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive2(1, 1, 1, 0, 0, 64'h3000 + 64'(k), '0, 16'hFFFF, 8'h02);
      tick();
    end
    if2.rx_st_valid = 1'b0;
    check("of_level", lvl2, 8);
    check("of_ovf", ovf2, 1);
    check("of_head", if2.out_data[63:0], 64'h3000);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("clr_ovf", ovf2, 0);
    check("clr_pkt", pkt2, 0);
    check("clr_level", lvl2, 8);
    if2.out_ready = 1'b1;
    drive2(1, 1, 1, 0, 0, 64'h3009, '0, 16'hFFFF, 8'h02);
    tick();
    if2.rx_st_valid = 1'b0;
    check("fpw_level", lvl2, 8);
    check("fpw_ovf", ovf2, 0);
    check("fpw_head", if2.out_data[63:0], 64'h3001);
    for (int k = 0; k < 8; k++) tick();
    check("fpw_level0", lvl2, 0);
    check("fpw_pkt", pkt2, 9);

    // protocol: sop, sop, eop, stray eop; then clear on an eop pop
    drive2(1, 1, 0, 0, 0, 64'h50A0, '0, 16'hFFFF, 8'h03);
    tick();
    check("pr_a_data", if2.out_data[63:0], 64'h50A0);
    check("pr_a_err", pro2, 0);
    drive2(1, 1, 0, 0, 0, 64'h50B0, '0, 16'hFFFF, 8'h03);
    tick();
    check("pr_b_data", if2.out_data[63:0], 64'h50B0);
    check("pr_b_err", pro2, 1);
    drive2(1, 0, 1, 0, 0, 64'h50C0, '0, 16'hFFFF, 8'h03);
    tick();
    check("pr_c_data", if2.out_data[63:0], 64'h50C0);
    drive2(1, 0, 1, 0, 0, 64'h50D0, '0, 16'hFFFF, 8'h03);
    tick();
    check("pr_d_data", if2.out_data[63:0], 64'h50D0);
    check("pr_d_err", pro2, 1);
    if2.rx_st_valid = 1'b0;
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("pr_clr_pkt", pkt2, 0);
    check("pr_clr_err", pro2, 0);
    check("pr_clr_valid", if2.out_valid, 0);

    // asynchronous reset with beats buffered
    if2.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive2(1, 1, 1, 0, 0, 64'h6000 + 64'(k), '0, 16'hFFFF, 8'h05);
      tick();
    end
    if2.rx_st_valid = 1'b0;
    check("ar_level5", lvl2, 5);
    rstn = 1'b0;
    #1;
    check("ar_valid", if2.out_valid, 0);
    check("ar_level", lvl2, 0);
    check("ar_ready", if2.rx_st_ready, 0);
    check("ar_data", if2.out_data, 0);
    #1;
    rstn = 1'b1;
    tick();
    check("ar_ready_back", if2.rx_st_ready, 1);
    rx_stream_mask = 1'b1;
    tick();
    check("mask_ready", if2.rx_st_ready, 0);
    rx_stream_mask = 1'b0;
    tick();
    check("unmask_ready", if2.rx_st_ready, 1);

    // 4-lane single-beat packet with three empty lanes
    if4.rx_st_valid  = 1'b1;
    if4.rx_st_sop    = 1'b1;
    if4.rx_st_eop    = 1'b1;
    if4.rx_st_empty  = 2'd3;
    if4.rx_st_data   = {64'h4003, 64'h4002, 64'h4001, 64'h4000};
    if4.rx_st_be     = 32'h8844_2211;
    if4.rx_st_bardec = 8'h09;
    tick();
    if4.rx_st_valid = 1'b0;
    check("l4_lane0", if4.out_data[81:0], lw(8'h11, 1, 1, 8'h09, 64'h4000));
    check("l4_lane3", if4.out_data[327:246], lw(8'h88, 1, 0, 8'h09, 64'h4003));
    check("l4_vld", if4.out_lane_vld, 4'b0001);
    tick();
    check("l4_pkt", pkt4, 1);
    check("l4_proto", pro4, 0);
    check("l4_empty", if4.out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
